// File: rtl/id_stage_pipe.sv
// RV32I decode stage: register file with optional WB bypass, load-use hazard detection and ID/EX register.
// Latency 1 cycle; id_ready drops on EX backpressure, load-use hazard or flush.
module id_stage_pipe #(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int WB_BYPASS   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [XLEN-1:0]        if_inst,
    input  logic [XLEN-1:0]        if_pc,
    output logic                   id_ready,
    input  logic                   flush,
    input  logic                   ex_ready,
    input  logic                   wb_regwrite,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   ex_valid,
    output logic [XLEN-1:0]        ex_pc,
    output logic [XLEN-1:0]        ex_rs1_data,
    output logic [XLEN-1:0]        ex_rs2_data,
    output logic [XLEN-1:0]        ex_imm,
    output logic [REG_ADDR_W-1:0]  ex_rs1,
    output logic [REG_ADDR_W-1:0]  ex_rs2,
    output logic [REG_ADDR_W-1:0]  ex_rd,
    output logic [2:0]             ex_funct3,
    output logic                   ex_inst30,
    output logic [8:0]             ex_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [XLEN-1:0]       regs [NUM_REGS];
    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    logic                  branch, memread, memtoreg, memwrite, alusrc, regwrite, pcplus4;
    logic [1:0]            aluop;
    logic [8:0]            ctrl;
    logic [XLEN-1:0]       imm;
    logic                  use_rs1, use_rs2;
    logic [XLEN-1:0]       rs1_data, rs2_data;
    logic                  wb_hit_en;
    logic                  hazard, advance;

    assign opcode = if_inst[6:0];
    assign rd     = if_inst[11:7];
    assign rs1    = if_inst[19:15];
    assign rs2    = if_inst[24:20];

    always_comb begin
        branch = 1'b0; memread = 1'b0; memtoreg = 1'b0; memwrite = 1'b0;
        alusrc = 1'b0; regwrite = 1'b0; pcplus4 = 1'b0; aluop = 2'b00;
        imm = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                aluop = 2'b10; regwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_I: begin
                aluop = 2'b11; alusrc = 1'b1; regwrite = 1'b1; use_rs1 = 1'b1;
                imm = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
            end
            OP_LOAD: begin
                alusrc = 1'b1; memread = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; use_rs1 = 1'b1;
                imm = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
            end
            OP_STORE: begin
                alusrc = 1'b1; memwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm = {{(XLEN-12){if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            end
            OP_BRANCH: begin
                aluop = 2'b01; branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm = {{(XLEN-13){if_inst[31]}}, if_inst[31], if_inst[7],
                       if_inst[30:25], if_inst[11:8], 1'b0};
            end
            OP_JAL: begin
                branch = 1'b1; regwrite = 1'b1; pcplus4 = 1'b1;
                imm = {{(XLEN-21){if_inst[31]}}, if_inst[31], if_inst[19:12],
                       if_inst[20], if_inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign ctrl = {branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite, pcplus4};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_regwrite && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // A same-cycle write-back is forwarded only when bypass is enabled.
    assign wb_hit_en = (WB_BYPASS != 0) && wb_regwrite && (wb_rd != '0);

    always_comb begin
        rs1_data = regs[rs1];
        if (rs1 == '0)                    rs1_data = '0;
        else if (wb_hit_en && wb_rd == rs1) rs1_data = wb_data;
    end

    always_comb begin
        rs2_data = regs[rs2];
        if (rs2 == '0)                    rs2_data = '0;
        else if (wb_hit_en && wb_rd == rs2) rs2_data = wb_data;
    end

    assign hazard  = ex_valid && ex_ctrl[7] && (ex_rd != '0) &&
                     ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));
    assign advance = !ex_valid || ex_ready;
    assign id_ready = advance && !hazard && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0; ex_pc <= '0; ex_rs1_data <= '0; ex_rs2_data <= '0;
            ex_imm <= '0; ex_rs1 <= '0; ex_rs2 <= '0; ex_rd <= '0;
            ex_funct3 <= '0; ex_inst30 <= 1'b0; ex_ctrl <= '0; stall_cnt <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (advance) begin
            if (if_valid && !hazard) begin
                ex_valid    <= 1'b1;
                ex_pc       <= if_pc;
                ex_rs1_data <= rs1_data;
                ex_rs2_data <= rs2_data;
                ex_imm      <= imm;
                ex_rs1      <= rs1;
                ex_rs2      <= rs2;
                ex_rd       <= rd;
                ex_funct3   <= if_inst[14:12];
                ex_inst30   <= if_inst[30];
                ex_ctrl     <= ctrl;
            end else begin
                // Here if_valid implies a load-use bubble.
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                if (if_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Next-generation instruction decode stage for the pipelined RISC-V core. It decodes one RV32I instruction per cycle, reads the internal register file with write-back bypass, and detects load-use hazards. It holds the ID/EX pipeline register behind a valid/ready handshake with stall, bubble and flush. The block sits between the IF/ID register and the EX stage.

Parameters:
XLEN, 32, data/instruction width
NUM_REGS, 32, architectural registers (x0 hardwired to zero)
REG_ADDR_W, 5, register index width (log2 NUM_REGS)
WB_BYPASS, 1, 1 = same-cycle WB write visible at read ports; 0 = no bypass
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
if_valid  in  1  IF/ID holds a valid instruction
if_inst  in  XLEN  instruction
if_pc  in  XLEN  instruction PC
id_ready  out  1  ID accepts if_inst this cycle
flush  in  1  kill ID/EX contents and the incoming instruction (branch taken)
ex_ready  in  1  EX consumes ID/EX contents this cycle
wb_regwrite  in  1  write-back enable
wb_rd  in  REG_ADDR_W  write-back destination
wb_data  in  XLEN  write-back data
ex_valid  out  1  ID/EX register valid
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered operands/immediate
ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W each  registered indices
ex_funct3  out  3  registered funct3
ex_inst30  out  1  registered inst[30]
ex_ctrl  out  9  {branch, memread, memtoreg, aluop[1:0], memwrite, alusrc, regwrite, getpcplus4}
stall_cnt  out  STALL_CNT_W  count of load-use bubble cycles, saturating

Behaviour:
- Reset (async, rst=1): every output register = 0, all registers in the file = 0, stall_cnt = 0. id_ready is combinational and resolves from the cleared state. Reset mid-stall drops the stalled instruction.
- Decode by opcode:
  - R 0110011: aluop=10, regwrite=1.
  - I 0010011: aluop=11, alusrc=1, regwrite=1.
  - LOAD 0000011: aluop=00, alusrc=1, memread=1, memtoreg=1, regwrite=1.
  - STORE 0100011: aluop=00, alusrc=1, memwrite=1.
  - BRANCH 1100011: aluop=01, branch=1.
  - JAL 1101111: branch=1, regwrite=1, getpcplus4=1.
  - Any other opcode: ex_ctrl=0; the instruction still passes as valid (NOP).
- Immediates, sign-extended to XLEN: I for I/LOAD, S for STORE, B for BRANCH (bit0=0), J for JAL (bit0=0). R and unknown opcodes give 0.
- Source use: rs1 is used by R/I/LOAD/STORE/BRANCH. rs2 is used by R/STORE/BRANCH.
- Register file:
  - Write at rising clk when wb_regwrite && wb_rd!=0. Writes to x0 are ignored.
  - Reads are combinational. Index 0 reads 0.
  - With WB_BYPASS=1, a read index equal to wb_rd (nonzero, wb_regwrite=1) returns wb_data in the same cycle.
- advance = !ex_valid || ex_ready.
- Load-use hazard = ex_valid && ex_ctrl.memread && ex_rd!=0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)), evaluated against the current if_inst.
- id_ready = advance && !hazard && !flush.
- At each rising edge, in priority order:
  1. flush: ex_valid<=0; the incoming instruction is not accepted.
  2. advance && hazard && if_valid: ex_valid<=0 (bubble), stall_cnt += 1 (saturates at all-ones).
  3. advance && if_valid: load the ID/EX register with the decoded instruction, ex_valid<=1.
  4. advance && !if_valid: ex_valid<=0.
  5. !advance: hold every ID/EX field.
- Simultaneous WB write and ID/EX load: the data captured uses the bypassed value when WB_BYPASS=1, otherwise the pre-write value.
- Latency: an accepted instruction appears on ex_* one cycle later. Throughput is 1/cycle absent hazards.
- Bubble fields: when ex_valid=0 due to bubble or flush, ex_ctrl=0; other fields are don't-care.

Test Plan:
- Reset during operation -> all ex_* = 0, ex_valid=0, stall_cnt=0; read of x5 returns 0 after release.
- WB x3=0x1234 (wb_regwrite=1) same cycle as `add x4,x3,x3` (0x00318233) with WB_BYPASS=1 -> next cycle ex_rs1_data=ex_rs2_data=0x1234, ex_ctrl aluop=10, regwrite=1; with WB_BYPASS=0 -> 0x0.
- `lw x5,8(x0)` then `add x6,x5,x1`:
  - add cycle: id_ready=0, then bubble (ex_valid=0, ex_ctrl=0), stall_cnt=1.
  - Following cycle: add accepted with ex_rd=6.
- `sw x5,-4(x2)` after `lw x5` -> hazard. `jal x1,-8` after `lw x5` -> no hazard; ex_imm=0xFFFFFFF8, getpcplus4=1.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ID/EX fields unchanged, id_ready=0; ex_ready=1 -> next instruction loads.
- flush=1 with if_valid=1 -> id_ready=0, next cycle ex_valid=0; writes to x0 via wb leave x0 reading 0.
